fifo_wr_arbiter: RTL and testbench

- Write-side controller for the 4-bit dual-clock FIFO. Shares the single FIFO push port among NREQ requesters in the WR_CLK domain.
- Uses round-robin arbitration with bounded bursts and honours the FIFO Full flag.
- Drives the FIFO push and Data_In pins directly, and exposes per-beat acknowledges plus throughput and stall statistics.

---
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the 4-bit dual-clock FIFO: round-robin grants with bounded
// bursts, Full-aware push strobe, and saturating push/stall statistics.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              WR_CLK,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_data,
    input  logic              fifo_full,
    output logic              fifo_push,
    output logic [3:0]        fifo_data,
    output logic [NREQ-1:0]   ack,
    output logic [1:0]        owner,
    output logic              busy,
    output logic [CNT_W-1:0]  push_count,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [4:0] BURST_LAST = 5'(MAX_BURST);

    state_t           state_q, state_d;
    logic [1:0]       owner_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] push_count_d, stall_count_d;
    logic             found;
    logic [1:0]       pick;
    logic [1:0]       cand;
    logic             stall;
    logic             last_beat;

    assign busy = (state_q == GRANT);

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        push_count_d  = push_count;
        stall_count_d = stall_count;
        fifo_push     = 1'b0;
        fifo_data     = '0;
        ack           = '0;
        stall         = 1'b0;
        last_beat     = 1'b0;
        found         = 1'b0;
        pick          = rr_ptr_q;
        cand          = '0;

        // First requester at or after the round-robin pointer, wrapping modulo 4.
        for (int i = 0; i < NREQ; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (en && found) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                fifo_data  = req_data[4*owner +: 4];
                fifo_push  = en & req[owner] & ~fifo_full;
                stall      = en & req[owner] & fifo_full;
                ack[owner] = fifo_push;
                last_beat  = fifo_push && (({1'b0, beat_cnt_q} + 5'd1) == BURST_LAST);

                if (fifo_push) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (push_count != '1) push_count_d = push_count + CNT_W'(1);
                end
                if (stall && (stall_count != '1)) stall_count_d = stall_count + CNT_W'(1);

                // A stalled burst is held; only burst length, req drop or disable end it.
                if (last_beat || !req[owner] || !en) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner       <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            push_count  <= '0;
            stall_count <= '0;
        end else begin
            state_q     <= state_d;
            owner       <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            push_count  <= push_count_d;
            stall_count <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: each scenario queues the beats it expects and a
// negedge monitor pops and compares them as the arbiter pushes.
module tb_fifo_wr_arbiter;

    logic        WR_CLK = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic        fifo_full;

    logic        fifo_push;
    logic [3:0]  fifo_data;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] push_count;
    logic [15:0] stall_count;

    // Narrow-counter copy on the same stimulus, used to observe saturation quickly.
    logic        s_push;
    logic [3:0]  s_data;
    logic [3:0]  s_ack;
    logic [1:0]  s_owner;
    logic        s_busy;
    logic [1:0]  s_push_count;
    logic [1:0]  s_stall_count;

    typedef struct packed {
        logic [1:0] owner;
        logic [3:0] data;
    } beat_t;

    beat_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;

    fifo_wr_arbiter #(.NREQ(4), .MAX_BURST(4), .CNT_W(16)) dut (
        .WR_CLK(WR_CLK), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data(fifo_data), .ack(ack),
        .owner(owner), .busy(busy), .push_count(push_count), .stall_count(stall_count)
    );

    fifo_wr_arbiter #(.NREQ(4), .MAX_BURST(4), .CNT_W(2)) u_sat (
        .WR_CLK(WR_CLK), .rst(rst), .en(en), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .fifo_push(s_push), .fifo_data(s_data), .ack(s_ack),
        .owner(s_owner), .busy(s_busy), .push_count(s_push_count), .stall_count(s_stall_count)
    );

    always #5 WR_CLK = ~WR_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every pushed beat must match the next queued beat.
    always @(negedge WR_CLK) begin
        beat_t      exp_beat;
        logic [3:0] exp_ack;
        n_total++;
        if (fifo_push) begin
            if (sb.size() == 0) begin
                $display("FAIL unexpected_push: owner=%0d data=%h with empty scoreboard", owner, fifo_data);
            end else begin
                exp_beat = sb.pop_front();
                exp_ack  = 4'b0001 << exp_beat.owner;
                if (owner !== exp_beat.owner || fifo_data !== exp_beat.data || ack !== exp_ack || fifo_full !== 1'b0)
                    $display("FAIL beat: got owner=%0d data=%h ack=%b full=%b, want owner=%0d data=%h ack=%b full=0",
                             owner, fifo_data, ack, fifo_full, exp_beat.owner, exp_beat.data, exp_ack);
                else n_pass++;
            end
        end else begin
            if (ack !== 4'b0000 || (!busy && fifo_data !== 4'h0))
                $display("FAIL idle_outputs: got ack=%b data=%h busy=%b, want ack=0000 (data=0 when idle)",
                         ack, fifo_data, busy);
            else n_pass++;
        end
    end

    task automatic next_edge();
        @(posedge WR_CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_edge();
        next_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 4'b1111; req_data = 16'hFFFF; fifo_full = 1'b0;
        @(negedge WR_CLK);
        n_total++;
        if ({fifo_push, ack, fifo_data, owner, busy} !== 12'h000)
            $display("FAIL reset_outputs: got push=%b ack=%b data=%h owner=%0d busy=%b, want all 0",
                     fifo_push, ack, fifo_data, owner, busy);
        else n_pass++;
        n_total++;
        if (push_count !== 16'h0 || stall_count !== 16'h0)
            $display("FAIL reset_counters: got push=%h stall=%h, want 0000/0000", push_count, stall_count);
        else n_pass++;
        req = 4'b0000; en = 1'b0;
        next_edge();
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        do_reset();
        en = 1'b1; fifo_full = 1'b0; req_data = 16'h000A; req = 4'b0001;
        repeat (4) sb.push_back(beat_t'{2'd0, 4'hA});
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b0) $display("FAIL arb_latency: got busy=%b, want 0 before first edge", busy);
        else n_pass++;
        next_edge();
        for (int c = 0; c < 4; c++) begin
            @(negedge WR_CLK);
            n_total++;
            if (busy !== 1'b1 || fifo_push !== 1'b1)
                $display("FAIL burst_beat%0d: got busy=%b push=%b, want 1/1", c, busy, fifo_push);
            else n_pass++;
            next_edge();
        end
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b0 || fifo_push !== 1'b0 || push_count !== 16'd4)
            $display("FAIL bubble: got busy=%b push=%b count=%0d, want 0/0/4", busy, fifo_push, push_count);
        else n_pass++;
        next_edge();
        req = 4'b0000;
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b1 || owner !== 2'd0 || fifo_push !== 1'b0)
            $display("FAIL regrant: got busy=%b owner=%0d push=%b, want 1/0/0", busy, owner, fifo_push);
        else n_pass++;
        next_edge();
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b0 || push_count !== 16'd4 || sb.size() != 0)
            $display("FAIL single_end: got busy=%b count=%0d pending=%0d, want 0/4/0", busy, push_count, sb.size());
        else n_pass++;
        next_edge();
    endtask

    task automatic test_round_robin();
        int pushes = 0;
        do_reset();
        en = 1'b1; fifo_full = 1'b0; req_data = 16'h4321; req = 4'b1111;
        for (int o = 0; o < 5; o++)
            repeat (4) sb.push_back(beat_t'{2'(o % 4), 4'(o % 4 + 1)});
        for (int c = 0; c < 25; c++) begin
            @(negedge WR_CLK);
            if (fifo_push) pushes++;
            next_edge();
        end
        req = 4'b0000;
        n_total++;
        if (pushes != 20 || sb.size() != 0)
            $display("FAIL rr_throughput: got %0d beats, %0d pending in 25 cycles, want 20/0", pushes, sb.size());
        else n_pass++;
        n_total++;
        if (push_count !== 16'd20 || s_push_count !== 2'b11)
            $display("FAIL rr_counts: got push=%0d sat=%0d, want 20/3", push_count, s_push_count);
        else n_pass++;
        next_edge();
    endtask

    task automatic test_full_stall();
        do_reset();
        en = 1'b1; fifo_full = 1'b0; req_data = 16'h0C00; req = 4'b0100;
        repeat (4) sb.push_back(beat_t'{2'd2, 4'hC});
        @(negedge WR_CLK);
        next_edge();
        repeat (2) begin
            @(negedge WR_CLK);
            next_edge();
        end
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge WR_CLK);
            n_total++;
            if (fifo_push !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1)
                $display("FAIL stall_hold%0d: got push=%b ack=%b busy=%b, want 0/0000/1", c, fifo_push, ack, busy);
            else n_pass++;
            next_edge();
        end
        fifo_full = 1'b0;
        @(negedge WR_CLK);
        n_total++;
        if (fifo_push !== 1'b1) $display("FAIL full_resume: got push=%b, want 1 same cycle", fifo_push);
        else n_pass++;
        next_edge();
        @(negedge WR_CLK);
        next_edge();
        @(negedge WR_CLK);
        req = 4'b0000;
        n_total++;
        if (busy !== 1'b0 || sb.size() != 0)
            $display("FAIL stall_end: got busy=%b pending=%0d, want 0/0", busy, sb.size());
        else n_pass++;
        n_total++;
        if (stall_count !== 16'd5 || push_count !== 16'd4 || s_stall_count !== 2'b11 || s_push_count !== 2'b11)
            $display("FAIL stall_counts: got stall=%0d push=%0d sat=%0d/%0d, want 5/4/3/3",
                     stall_count, push_count, s_stall_count, s_push_count);
        else n_pass++;
        next_edge();
    endtask

    task automatic test_drop_req();
        do_reset();
        en = 1'b1; fifo_full = 1'b0; req_data = 16'h9056; req = 4'b1010;
        repeat (2) sb.push_back(beat_t'{2'd1, 4'h5});
        repeat (4) sb.push_back(beat_t'{2'd3, 4'h9});
        @(negedge WR_CLK);
        next_edge();
        repeat (2) begin
            @(negedge WR_CLK);
            next_edge();
        end
        req = 4'b1001;
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b1 || fifo_push !== 1'b0)
            $display("FAIL drop_no_push: got busy=%b push=%b, want 1/0", busy, fifo_push);
        else n_pass++;
        next_edge();
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b0) $display("FAIL drop_bubble: got busy=%b, want 0", busy);
        else n_pass++;
        next_edge();
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b1 || owner !== 2'd3)
            $display("FAIL rr_after_drop: got busy=%b owner=%0d, want 1/3", busy, owner);
        else n_pass++;
        next_edge();
        repeat (3) begin
            @(negedge WR_CLK);
            next_edge();
        end
        req = 4'b0000;
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b0 || sb.size() != 0)
            $display("FAIL drop_end: got busy=%b pending=%0d, want 0/0", busy, sb.size());
        else n_pass++;
        next_edge();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b1; fifo_full = 1'b0; req_data = 16'h00E7; req = 4'b0001;
        repeat (2) sb.push_back(beat_t'{2'd0, 4'h7});
        sb.push_back(beat_t'{2'd1, 4'hE});
        @(negedge WR_CLK);
        next_edge();
        repeat (2) begin
            @(negedge WR_CLK);
            next_edge();
        end
        en = 1'b0;
        @(negedge WR_CLK);
        n_total++;
        if (fifo_push !== 1'b0 || ack !== 4'b0000)
            $display("FAIL en_drop_push: got push=%b ack=%b, want 0/0000", fifo_push, ack);
        else n_pass++;
        next_edge();
        req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            @(negedge WR_CLK);
            n_total++;
            if (busy !== 1'b0) $display("FAIL no_grant_disabled%0d: got busy=%b, want 0", c, busy);
            else n_pass++;
            next_edge();
        end
        en = 1'b1;
        @(negedge WR_CLK);
        next_edge();
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b1 || owner !== 2'd1 || fifo_push !== 1'b1)
            $display("FAIL en_resume_rr: got busy=%b owner=%0d push=%b, want 1/1/1", busy, owner, fifo_push);
        else n_pass++;
        next_edge();
        req = 4'b0000;
        @(negedge WR_CLK);
        next_edge();
        n_total++;
        if (push_count !== 16'd3 || sb.size() != 0 || busy !== 1'b0)
            $display("FAIL en_end: got count=%0d pending=%0d busy=%b, want 3/0/0", push_count, sb.size(), busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; fifo_full = 1'b0; req_data = 16'h0B00; req = 4'b0100;
        repeat (2) sb.push_back(beat_t'{2'd2, 4'hB});
        @(negedge WR_CLK);
        next_edge();
        @(negedge WR_CLK);
        next_edge();
        @(negedge WR_CLK);
        n_total++;
        if (fifo_push !== 1'b1 || owner !== 2'd2 || push_count !== 16'd1)
            $display("FAIL pre_reset: got push=%b owner=%0d count=%0d, want 1/2/1", fifo_push, owner, push_count);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({fifo_push, ack, busy, owner} !== 8'h00)
            $display("FAIL async_reset_outputs: got push=%b ack=%b busy=%b owner=%0d, want all 0",
                     fifo_push, ack, busy, owner);
        else n_pass++;
        n_total++;
        if (push_count !== 16'h0 || stall_count !== 16'h0)
            $display("FAIL async_reset_counters: got push=%0d stall=%0d, want 0/0", push_count, stall_count);
        else n_pass++;
        req = 4'b0000;
        next_edge();
        rst = 1'b0;
        @(negedge WR_CLK);
        n_total++;
        if (busy !== 1'b0 || sb.size() != 0 || push_count !== 16'h0)
            $display("FAIL post_reset: got busy=%b pending=%0d count=%0d, want 0/0/0", busy, sb.size(), push_count);
        else n_pass++;
        next_edge();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_drop_req();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
